// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the 8-bit PC, fetches over req/ack,
// issues over valid/ready and resolves jumps and zero-flag branches.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] HALT_OP  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic       instr_valid,
  output logic [7:0] instr,
  input  logic       instr_ready,
  input  logic       zero_flag,
  output logic [7:0] pc,
  output logic [7:0] pc_control,
  output logic [7:0] jump_offset,
  output logic       halted,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on the rising edge where the producer's
  // request/valid and the consumer's ack/ready are both high.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic       is_halt;
  logic       is_jump;
  logic       is_branch;
  logic       taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // HALT_OP sits in the branch encoding space but must never redirect.
  always_comb begin
    is_halt   = (instr_q == HALT_OP);
    is_jump   = (instr_q[7:6] == 2'b10);
    is_branch = (instr_q[7:6] == 2'b11) && !is_halt;
    taken     = is_jump || (is_branch && zero_flag);
  end

  assign pc_control  = taken ? 8'hFF : 8'h00;
  assign jump_offset = {{2{instr_q[5]}}, instr_q[5:0]};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          if (is_halt) begin
            state_d = S_HALTED;
          end else begin
            pc_d    = pc_q + 8'd1 + (pc_control & jump_offset);
            state_d = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign halted      = (state_q == S_HALTED);
  assign dbg_state   = state_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns and sequences the 8-bit program counter. It fetches one instruction per cycle pair from instruction memory over a req/ack handshake and hands it downstream over a valid/ready handshake. It resolves jumps and zero-flag branches and advances the PC with the team's next-PC rule: pc + 1 + (pc_control & jump_offset). It sits between instruction memory and the decode/execute stage, and is the only writer of the PC.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_OP, 8'hFF, instruction encoding that stops fetching.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level; leaves IDLE when high; ignored in every other state.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  8  fetch address; equals pc while imem_req=1.
- imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req=0.
- imem_rdata  input  8  fetched instruction.
- instr_valid  output  1  instr is valid for downstream.
- instr  output  8  registered instruction captured from imem_rdata.
- instr_ready  input  1  downstream accepts instr.
- zero_flag  input  1  branch condition from execute; sampled on the issue handshake edge.
- pc  output  8  current program counter.
- pc_control  output  8  8'hFF when the issued instruction redirects, else 8'h00; combinational from instr and zero_flag.
- jump_offset  output  8  sign-extended offset, instr[5:0] to 8 bits.
- halted  output  1  high in HALTED.

## Operation
- Instruction classes:
  - instr == HALT_OP: halt. Not taken. The PC does not advance.
  - instr[7:6] == 2'b10: unconditional jump. Taken.
  - instr[7:6] == 2'b11 and not HALT_OP: branch. Taken iff zero_flag=1.
  - Anything else: sequential. Not taken.
- Next PC on issue handshake: pc <= pc + 8'd1 + (pc_control & jump_offset), modulo 256. Carries are discarded.
- Offset 6'h3F (-1) taken gives next pc = pc, a self-loop. Offset 6'h20 gives -32.
- States:
  - IDLE: all handshake outputs low. Go to FETCH when start=1.
  - FETCH: imem_req=1, imem_addr=pc. When imem_ack=1, capture instr <= imem_rdata and go to ISSUE.
  - ISSUE: instr_valid=1, instr held stable. When instr_ready=1:
    - If instr == HALT_OP, go to HALTED; pc unchanged.
    - Otherwise update pc and go to FETCH.
  - HALTED: halted=1; imem_req=0 and instr_valid=0. Exited only by rst_n.
- While in ISSUE with instr_ready=0, pc, instr and pc_control hold. pc_control may change if zero_flag changes before acceptance; only the value on the handshake edge counts.
- imem_rdata is ignored outside FETCH-with-ack.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=8'h00.
  - imem_req=0, instr_valid=0, halted=0.
  - imem_addr=RESET_PC.
  - pc_control=8'h00, jump_offset=8'h00, since instr=0 is sequential.
- Release is synchronous to clk. The first FETCH begins one cycle after start is sampled high.
- Fetch latency: imem_ack in the same cycle as imem_req is accepted, giving a 1-cycle FETCH. Each cycle of ack delay adds one cycle.
- Issue: instr_valid rises the cycle after the ack edge. The new pc is visible the cycle after the ready edge, coincident with imem_req for the next fetch.
- Best-case throughput: one instruction per 2 cycles.
- Reset mid-FETCH or mid-ISSUE aborts immediately. No instruction is issued and pc returns to RESET_PC.
- A simultaneous imem_ack and start in IDLE has no effect on the ack, because imem_req=0.

## Test plan
- Reset, start=1, memory returns 8'h01 with same-cycle ack, ready tied high -> pc sequence 0,1,2,3 advancing every 2 cycles; instr_valid pulses 1 cycle each.
- At pc=8'h05 fetch 8'b10_000011 (jump +3) -> pc_control=8'hFF, jump_offset=8'h03, next pc=8'h09.
- At pc=8'h10 fetch 8'b11_111110 (branch -2): with zero_flag=0 -> next pc=8'h11; with zero_flag=1 -> next pc=8'h0F.
- At pc=8'hFF fetch a sequential op -> pc wraps to 8'h00. At pc=8'hFE, jump +3 -> pc=8'h02.
- Ack delayed 3 cycles and ready withheld 4 cycles -> imem_req held with a stable imem_addr; instr and pc stable; exactly one pc update per instruction.
- Fetch HALT_OP at pc=8'h07 -> halted=1, pc stays 8'h07, no further imem_req, start ignored. Assert rst_n=0 mid-ISSUE in another run -> all outputs at reset values asynchronously.
